// File: rtl/ddr_phy_dqsw_gen.sv
// DQS write-path sequencer: per-lane DQS serializer pattern/OEN slices and DQ strobes,
// driven from a shift-register delay line with runtime write latency and BL4/BL8 bursts.
module ddr_phy_dqsw_gen #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned MAX_WL = 15
) (
    input  logic                 clk100m,
    input  logic                 phy_rst,
    input  logic                 write,
    input  logic                 burst8,
    input  logic [3:0]           wl,
    input  logic [LANES-1:0]     lane_en,
    input  logic                 wl_mode,
    input  logic                 wl_pulse,
    output logic [8*LANES-1:0]   dqs_pat,
    output logic [4*LANES-1:0]   dqs_oen,
    output logic                 write_start,
    output logic                 write_main,
    output logic                 write_end,
    output logic                 busy,
    output logic                 err_collision
);

    localparam int unsigned DEPTH = MAX_WL + 5;

    logic [DEPTH:1] vld_q;
    logic [DEPTH:1] bl8_q;
    logic           pulse_q;
    logic           err_q;

    int unsigned    we;
    logic           wr_acc;
    logic           dem_h;
    logic           dem_l;
    logic           start_c;
    logic           main_c;
    logic           end_c;
    logic           coll_c;

    function automatic int unsigned burst_cycles(input logic b8);
        return b8 ? 32'd4 : 32'd2;
    endfunction

    // Write-leveling mode swallows write commands entirely.
    assign wr_acc = write & ~wl_mode;

    // Effective latency: at least 2 so the preamble tap is never tap 0.
    always_comb begin
        we = 32'(wl);
        if (we < 32'd2) we = 32'd2;
        if (we > MAX_WL) we = MAX_WL;
    end

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            vld_q   <= '0;
            bl8_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q   <= {vld_q[DEPTH-1:1], wr_acc};
            bl8_q   <= {bl8_q[DEPTH-1:1], burst8};
            pulse_q <= wl_mode & wl_pulse & ~pulse_q;
            if (wr_acc && coll_c) err_q <= 1'b1;
        end
    end

    // Every in-flight command contributes preamble/data/postamble demands by its tap position.
    always_comb begin
        dem_h   = 1'b0;
        dem_l   = 1'b0;
        start_c = 1'b0;
        main_c  = 1'b0;
        end_c   = 1'b0;
        coll_c  = 1'b0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (vld_q[k]) begin
                if (k == we - 32'd1) dem_h = 1'b1;
                if (k >= we && k <= we + burst_cycles(bl8_q[k]) - 32'd1) begin
                    dem_h = 1'b1;
                    dem_l = 1'b1;
                end
                if (k == we + burst_cycles(bl8_q[k])) begin
                    dem_l = 1'b1;
                    end_c = 1'b1;
                end
                if (k == we) start_c = 1'b1;
                if (k >= we + 32'd1 && k + 32'd2 <= we + burst_cycles(bl8_q[k])) main_c = 1'b1;
                if (k < burst_cycles(bl8_q[k])) coll_c = 1'b1;
            end
        end
        if (pulse_q) begin
            dem_h = 1'b1;
            dem_l = 1'b1;
        end
    end

    always_comb begin
        dqs_oen = '1;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_en[i]) dqs_oen[4*i +: 4] = {~dem_h, ~dem_h, ~dem_l, ~dem_l};
        end
    end

    assign dqs_pat       = {LANES{8'b1111_0000}};
    assign write_start   = start_c;
    assign write_main    = main_c;
    assign write_end     = end_c;
    assign busy          = (|vld_q) | pulse_q;
    assign err_collision = err_q;

endmodule
